// File: rtl/exp_add_arb.sv
// exp_add_arb: round-robin shared posit exponent-sum datapath with a one-stage output register
module exp_add_arb #(
    parameter int n         = 16,
    parameter int es        = 1,
    parameter int N_REQ     = 4,
    parameter int LZC_WIDTH = $clog2(n - 1),
    parameter int EXP_WIDTH = LZC_WIDTH + 1 + es,
    parameter int IDW       = $clog2(N_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ*(LZC_WIDTH+1)-1:0] k_sgn_a_i,
    input  logic [N_REQ*(es+1)-1:0]        exp_a_i,
    input  logic [N_REQ*(LZC_WIDTH+1)-1:0] k_sgn_b_i,
    input  logic [N_REQ*(es+1)-1:0]        exp_b_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [EXP_WIDTH:0]             exp_o,
    output logic [IDW-1:0]                 out_id_o
);
    localparam int KW = LZC_WIDTH + 1;
    localparam int EW = es + 1;

    logic [IDW-1:0]   r_ptr, r_id, w_gnt, w_idx;
    logic             r_valid, w_gnt_vld, w_accept, w_fire;
    logic [EXP_WIDTH:0] r_exp, w_exp;
    logic [KW-1:0]    w_ka, w_kb;
    logic [EW-1:0]    w_ea, w_eb, w_raw;
    logic [KW:0]      w_kc;

    // pick the first valid requester after the last winner; descending scan leaves the nearest one
    always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        w_idx     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_idx = IDW'((int'(r_ptr) + i) % N_REQ);
            if (req_valid_i[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    assign w_ka  = k_sgn_a_i[int'(w_gnt)*KW +: KW];
    assign w_kb  = k_sgn_b_i[int'(w_gnt)*KW +: KW];
    assign w_ea  = exp_a_i[int'(w_gnt)*EW +: EW];
    assign w_eb  = exp_b_i[int'(w_gnt)*EW +: EW];
    assign w_raw = w_ea + w_eb;
    assign w_kc  = {w_ka[KW-1], w_ka} + {w_kb[KW-1], w_kb} + (KW+1)'(w_raw[es]);

    // exponent carry folds into k; remaining low exponent bits sit under the shifted k
    if (es == 0) begin : g_es0
        assign w_exp = w_kc;
    end else begin : g_esn
        assign w_exp = {w_kc, w_raw[es-1:0]};
    end

    assign w_accept    = !r_valid || out_ready_i;
    assign w_fire      = w_accept && w_gnt_vld && !flush_i;
    assign req_ready_o = (w_fire && !rst_i) ? N_REQ'(1) << w_gnt : '0;

    // output register and round-robin pointer; flush only clears valid, pointer moves on handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_exp   <= '0;
            r_id    <= '0;
            r_ptr   <= IDW'(N_REQ - 1);
        end else begin
            if (w_fire) begin
                r_exp <= w_exp;
                r_id  <= w_gnt;
                r_ptr <= w_gnt;
            end
            r_valid <= flush_i ? 1'b0 : w_fire ? 1'b1 : out_ready_i ? 1'b0 : r_valid;
        end
    end

    assign out_valid_o = r_valid;
    assign exp_o       = r_exp;
    assign out_id_o    = r_id;
endmodule

// File: tb/tb_exp_add_arb.sv
// tb_exp_add_arb: directed checks of arbitration, arithmetic, backpressure, flush and async reset
module tb_exp_add_arb;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, out_ready = 1'b1;
    logic [3:0]  rv = '0, rr;
    logic [19:0] ka = '0, kb = '0;
    logic [7:0]  ea = '0, eb = '0;
    logic        ov;
    logic [6:0]  eo;
    logic [1:0]  id;
    logic [3:0]  rv0 = '0, rr0;
    logic [19:0] ka0 = '0, kb0 = '0;
    logic [3:0]  ea0 = '0, eb0 = '0;
    logic        ov0;
    logic [5:0]  eo0;
    logic [1:0]  id0;
    int          n_tests = 0, n_fail = 0;

    exp_add_arb #(.n(16), .es(1), .N_REQ(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(rv), .req_ready_o(rr),
        .k_sgn_a_i(ka), .exp_a_i(ea), .k_sgn_b_i(kb), .exp_b_i(eb),
        .out_valid_o(ov), .out_ready_i(out_ready), .exp_o(eo), .out_id_o(id)
    );

    exp_add_arb #(.n(16), .es(0), .N_REQ(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .req_valid_i(rv0), .req_ready_o(rr0),
        .k_sgn_a_i(ka0), .exp_a_i(ea0), .k_sgn_b_i(kb0), .exp_b_i(eb0),
        .out_valid_o(ov0), .out_ready_i(1'b1), .exp_o(eo0), .out_id_o(id0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input int a, input int xa, input int b, input int xb);
        ka[r*5 +: 5] = 5'(a);
        ea[r*2 +: 2] = 2'(xa);
        kb[r*5 +: 5] = 5'(b);
        eb[r*2 +: 2] = 2'(xb);
    endtask

    initial begin
        rv = 4'hF;
        #1;
        check("rst_valid", 32'(ov), 32'd0);
        check("rst_exp", 32'(eo), 32'd0);
        check("rst_id", 32'(id), 32'd0);
        check("rst_ready", 32'(rr), 32'd0);
        check("rst_valid_es0", 32'(ov0), 32'd0);
        rv = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        set_op(2, 2, 1, 1, 1);
        rv = 4'b0100;
        #1;
        check("single_ready", 32'(rr), 32'h4);
        tick();
        check("single_valid", 32'(ov), 32'd1);
        check("single_exp", 32'(eo), 32'd8);
        check("single_id", 32'(id), 32'd2);
        rv = '0;
        #1;
        check("idle_ready", 32'(rr), 32'd0);
        tick();
        check("drain_valid", 32'(ov), 32'd0);
        check("drain_hold_exp", 32'(eo), 32'd8);

        set_op(1, -3, 0, 1, 1);
        rv = 4'b0010;
        ka0[4:0] = 5'b11101;
        ea0[0] = 1'b0;
        kb0[4:0] = 5'd1;
        eb0[0] = 1'b1;
        rv0 = 4'b0001;
        #1;
        check("neg_ready", 32'(rr), 32'h2);
        check("es0_ready", 32'(rr0), 32'h1);
        tick();
        check("neg_exp", 32'(eo), 32'h7D);
        check("neg_id", 32'(id), 32'd1);
        check("es0_exp", 32'(eo0), 32'h3F);
        check("es0_valid", 32'(ov0), 32'd1);
        rv = '0;
        rv0 = '0;
        tick();

        for (int r = 0; r < 4; r++) set_op(r, r, 0, 0, 0);
        rv = 4'hF;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("rr_ready", 32'(rr), 32'(1 << ((2 + i) % 4)));
            tick();
            check("rr_id", 32'(id), 32'((2 + i) % 4));
            check("rr_exp", 32'(eo), 32'(2 * ((2 + i) % 4)));
            check("rr_valid", 32'(ov), 32'd1);
        end

        out_ready = 1'b0;
        #1;
        check("stall_ready0", 32'(rr), 32'd0);
        repeat (3) begin
            tick();
            check("stall_id", 32'(id), 32'd3);
            check("stall_exp", 32'(eo), 32'd6);
            check("stall_valid", 32'(ov), 32'd1);
            check("stall_ready", 32'(rr), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", 32'(rr), 32'h1);
        tick();
        check("release_id", 32'(id), 32'd0);
        check("release_exp", 32'(eo), 32'd0);
        check("release_valid", 32'(ov), 32'd1);
        check("release_next_ready", 32'(rr), 32'h2);

        rv = 4'b0010;
        flush = 1'b1;
        #1;
        check("flush_ready", 32'(rr), 32'd0);
        tick();
        check("flush_valid", 32'(ov), 32'd0);
        flush = 1'b0;
        rv = 4'b0011;
        #1;
        check("post_flush_ready", 32'(rr), 32'h2);
        tick();
        check("post_flush_valid", 32'(ov), 32'd1);
        check("post_flush_id", 32'(id), 32'd1);
        check("post_flush_exp", 32'(eo), 32'd2);

        set_op(0, 1, 1, 0, 0);
        rv = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(ov), 32'd0);
        check("async_exp", 32'(eo), 32'd0);
        check("async_id", 32'(id), 32'd0);
        check("async_ready", 32'(rr), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("after_rst_ready", 32'(rr), 32'h1);
        tick();
        check("after_rst_id", 32'(id), 32'd0);
        check("after_rst_exp", 32'(eo), 32'd3);
        check("after_rst_valid", 32'(ov), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
